// File: rtl/mem_access.sv
// mem_access: byte-serial load/store stage that stalls the pipeline while it walks a 32-bit access over an 8-bit RAM.
// Defining MEM_ALIGN_CHECK_EN rejects misaligned halfword/word ops with a misalign_o pulse.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    output logic [31:0] mem_a_o,
    output logic [7:0]  mem_dout_o,
    output logic        mem_wr_o,
    input  logic [7:0]  mem_din_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o,
    output logic        misalign_o
);
    localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4, OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] ld_buf;
    logic [2:0]  n;
    logic        is_store, mis, start, issue, stall;
    logic [31:0] load_val;
    always_comb begin
        n = (mem_op_i == OP_LB || mem_op_i == OP_LBU || mem_op_i == OP_SB) ? 3'd1 :
            (mem_op_i == OP_LH || mem_op_i == OP_LHU || mem_op_i == OP_SH) ? 3'd2 :
            (mem_op_i == OP_LW || mem_op_i == OP_SW) ? 3'd4 : 3'd0;
        is_store = mem_op_i == OP_SB || mem_op_i == OP_SH || mem_op_i == OP_SW;
`ifdef MEM_ALIGN_CHECK_EN
        mis = state == IDLE && ((n == 3'd2 && mem_addr_i[0]) || (n == 3'd4 && mem_addr_i[1:0] != 2'd0));
`else
        mis = 1'b0;
`endif
        start = state == IDLE && n != 3'd0 && !mis;
        issue = start || (state == ACCESS && cnt < n);
        stall = start || state == ACCESS;
        // the load buffer keeps stale upper bytes from earlier ops, so narrow loads always re-extend
        load_val = (mem_op_i == OP_LB)  ? {{24{ld_buf[7]}}, ld_buf[7:0]} :
                   (mem_op_i == OP_LH)  ? {{16{ld_buf[15]}}, ld_buf[15:0]} :
                   (mem_op_i == OP_LBU) ? {24'd0, ld_buf[7:0]} :
                   (mem_op_i == OP_LHU) ? {16'd0, ld_buf[15:0]} : ld_buf;
        mem_a_o     = rst ? 32'd0 : mem_addr_i + {29'd0, cnt};
        mem_wr_o    = !rst && issue && is_store;
        mem_dout_o  = mem_wr_o ? mem_sdata_i[{cnt[1:0], 3'b000} +: 8] : 8'd0;
        stall_req_o = !rst && stall;
        misalign_o  = !rst && mis;
        wd_o        = rst ? 5'd0 : wd_i;
        wreg_o      = !rst && wreg_i && !stall && !mis;
        wdata_o     = rst ? 32'd0 : (state == DONE && n != 3'd0 && !is_store) ? load_val : wdata_i;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            ld_buf <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCESS;
                        cnt   <= 3'd1;
                    end
                end
                ACCESS: begin
                    // RAM data arriving now belongs to the byte issued last cycle
                    ld_buf[{cnt[1:0] - 2'd1, 3'b000} +: 8] <= mem_din_i;
                    if (cnt == n) begin
                        state <= DONE;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
